// File: rtl/link_seq_ctrl.sv
// link_seq_ctrl: bring-up / burst / fault sequencer for the transmit/receive link.
// Drives counter clear, counter enable and active-low converter enable toward the
// transmitter and counts receiver valid strobes during a burst.
// Optional build macro: LINK_SEQ_AUTO_RESTART_EN (DONE loops back to CLEAR).
module link_seq_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned CLR_CYCLES = 4,
  parameter int unsigned ARM_CYCLES = 5,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned TIMEOUT    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             clr_err,
  input  logic             valid,
  output logic             ctr_clr,
  output logic             ctr_en,
  output logic             conv_en_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic             BURST_EN   = (BURST_LEN != 0);
  localparam logic [CNT_W-1:0] BURST_LAST = BURST_EN ? CNT_W'(BURST_LEN - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;   // cycles spent in CLEAR / ARM
  logic [CNT_W-1:0] to_q, to_d;         // consecutive RUN cycles without valid
  logic [CNT_W-1:0] wc_q, wc_d;
  logic             ctr_clr_q, ctr_clr_d;
  logic             ctr_en_q, ctr_en_d;
  logic             conv_en_n_q, conv_en_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // State, timers, word counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      to_q        <= '0;
      wc_q        <= '0;
      ctr_clr_q   <= 1'b0;
      ctr_en_q    <= 1'b0;
      conv_en_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      to_q        <= to_d;
      wc_q        <= wc_d;
      ctr_clr_q   <= ctr_clr_d;
      ctr_en_q    <= ctr_en_d;
      conv_en_n_q <= conv_en_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next state, phase/timeout timers and word count
  always_comb begin
    state_d = state_q;
    to_d    = '0;
    wc_d    = wc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (abort)                    state_d = S_IDLE;
        else if (phase_q == CLR_LAST) state_d = S_ARM;
      end
      S_ARM: begin
        if (abort)                    state_d = S_IDLE;
        else if (phase_q == ARM_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (valid) begin
          wc_d = (wc_q == '1) ? wc_q : wc_q + CNT_W'(1);
          if (BURST_EN && (wc_q == BURST_LAST)) state_d = S_DONE;
        end else if (to_q == TO_LAST) begin
          state_d = S_FAULT;
        end else begin
          to_d = to_q + CNT_W'(1);
        end
      end
      S_DONE: begin
`ifdef LINK_SEQ_AUTO_RESTART_EN
        state_d = abort ? S_IDLE : S_CLEAR;
`else
        state_d = S_IDLE;
`endif
      end
      S_FAULT: begin
        if (clr_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Phase timer restarts on every state change, so each phase counts from zero
    if ((state_d == state_q) && ((state_q == S_CLEAR) || (state_q == S_ARM)))
      phase_d = phase_q + CNT_W'(1);
    else
      phase_d = '0;

    if ((state_d == S_CLEAR) && (state_q != S_CLEAR)) wc_d = '0;
  end

  // Output decode from the next state so registered outputs line up with state
  always_comb begin
    ctr_clr_d   = 1'b0;
    ctr_en_d    = 1'b0;
    conv_en_n_d = 1'b1;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_d)
      S_CLEAR: begin
        ctr_clr_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_ARM: begin
        ctr_en_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_RUN: begin
        ctr_en_d    = 1'b1;
        conv_en_n_d = 1'b0;
        busy_d      = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      S_FAULT: err_d  = 1'b1;
      default: ;
    endcase
  end

  assign ctr_clr    = ctr_clr_q;
  assign ctr_en     = ctr_en_q;
  assign conv_en_n  = conv_en_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign state      = state_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_link_seq_ctrl.sv
// Testbench for link_seq_ctrl: scenario tasks with a spec-level expectation model.
module tb_link_seq_ctrl;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned CLR   = 4;
  localparam int unsigned ARM   = 5;
  localparam int unsigned TO    = 32;
`ifdef LINK_SEQ_AUTO_RESTART_EN
  localparam int unsigned BL        = 4;
  localparam logic [2:0]  POST_DONE = 3'd1;
`else
  localparam int unsigned BL        = 16;
  localparam logic [2:0]  POST_DONE = 3'd0;
`endif
  localparam int unsigned ABORT_AT = (BL > 8) ? 8 : BL;

  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, ARMS = 3'd2, RUN = 3'd3,
                         DONE = 3'd4, FAULT = 3'd5;

  logic             clk = 1'b0;
  logic             rst, start, abort, clr_err, valid;
  logic             ctr_clr, ctr_en, conv_en_n, busy, done, err;
  logic [2:0]       state;
  logic [CNT_W-1:0] word_count;
  logic [8:0]       obs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  link_seq_ctrl #(
    .CNT_W(CNT_W), .CLR_CYCLES(CLR), .ARM_CYCLES(ARM), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .clr_err(clr_err),
    .valid(valid), .ctr_clr(ctr_clr), .ctr_en(ctr_en), .conv_en_n(conv_en_n),
    .busy(busy), .done(done), .err(err), .state(state), .word_count(word_count)
  );

  assign obs = {state, ctr_clr, ctr_en, conv_en_n, busy, done, err};

  // Expected {state, ctr_clr, ctr_en, conv_en_n, busy, done, err} for a state
  function automatic logic [8:0] spec_outs(input logic [2:0] st);
    logic clr, en, cn, b;
    clr = (st == CLEAR);
    en  = (st == ARMS) || (st == RUN);
    cn  = (st != RUN);
    b   = (st == CLEAR) || (st == ARMS) || (st == RUN);
    return {st, clr, en, cn, b, (st == DONE), (st == FAULT)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: start pulse, then advance to the first RUN cycle
  task automatic bring_up();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (CLR + ARM) tick();
  endtask

  // From the first RUN cycle, deliver BL words with gaps in [lo,hi]; ends on the DONE sample
  task automatic run_burst(input int unsigned lo, input int unsigned hi,
                           input bit force_max, input string tag);
    int unsigned g;
    for (int unsigned w = 0; w < BL; w++) begin
      g = (force_max && w == 0) ? TO - 1 : $urandom_range(hi, lo);
      valid = 1'b0;
      repeat (g) tick();
      n_cmp++;
      if (obs !== spec_outs(RUN) || word_count !== 16'(w)) begin
        n_bad++;
        $display("FAIL %s_gap[%0d]: got outs=%b wc=%0d want outs=%b wc=%0d",
                 tag, w, obs, word_count, spec_outs(RUN), w);
      end
      valid = 1'b1;
      tick();
      valid = 1'b0;
      n_cmp++;
      if (obs !== spec_outs((w + 1 == BL) ? DONE : RUN) || word_count !== 16'(w + 1)) begin
        n_bad++;
        $display("FAIL %s_word[%0d]: got outs=%b wc=%0d want outs=%b wc=%0d", tag, w, obs,
                 word_count, spec_outs((w + 1 == BL) ? DONE : RUN), w + 1);
      end
    end
  endtask

  // After the DONE sample: check the following state, then park in IDLE
  task automatic after_done(input string tag);
    tick();
    n_cmp++;
    if (obs !== spec_outs(POST_DONE) ||
        word_count !== ((POST_DONE == CLEAR) ? 16'd0 : 16'(BL))) begin
      n_bad++;
      $display("FAIL %s_post: got outs=%b wc=%0d want outs=%b", tag, obs, word_count,
               spec_outs(POST_DONE));
    end
    if (POST_DONE == CLEAR) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    tick();
    n_cmp++;
    if (obs !== spec_outs(IDLE)) begin
      n_bad++;
      $display("FAIL %s_idle: got outs=%b want %b", tag, obs, spec_outs(IDLE));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (obs !== spec_outs(IDLE) || word_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset: got outs=%b wc=%0d want outs=%b wc=0", obs, word_count, spec_outs(IDLE));
    end
    rst = 1'b0; start = 1'b0;
    tick();
    n_cmp++;
    if (obs !== spec_outs(IDLE)) begin
      n_bad++;
      $display("FAIL reset_idle: got outs=%b want %b", obs, spec_outs(IDLE));
    end
  endtask

  task automatic test_bringup();
    start = 1'b1; valid = 1'b1;   // start repeats and valid before RUN must be ignored
    tick();
    for (int unsigned i = 1; i <= CLR; i++) begin
      n_cmp++;
      if (obs !== spec_outs(CLEAR) || word_count !== 16'd0) begin
        n_bad++;
        $display("FAIL bringup_clear[%0d]: got outs=%b wc=%0d want outs=%b wc=0",
                 i, obs, word_count, spec_outs(CLEAR));
      end
      tick();
    end
    for (int unsigned i = 1; i <= ARM; i++) begin
      n_cmp++;
      if (obs !== spec_outs(ARMS)) begin
        n_bad++;
        $display("FAIL bringup_arm[%0d]: got outs=%b want %b", i, obs, spec_outs(ARMS));
      end
      if (i == ARM) start = 1'b0;
      tick();
    end
    valid = 1'b0;
    n_cmp++;
    if (obs !== spec_outs(RUN) || word_count !== 16'd0) begin
      n_bad++;
      $display("FAIL bringup_run: got outs=%b wc=%0d want outs=%b wc=0", obs, word_count, spec_outs(RUN));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (obs !== spec_outs(IDLE)) begin
      n_bad++;
      $display("FAIL bringup_abort: got outs=%b want %b", obs, spec_outs(IDLE));
    end
  endtask

  task automatic test_burst();
    bring_up();
    run_burst(2, 2, 1'b0, "burst3");
    after_done("burst3");
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      bring_up();
      run_burst(0, TO - 1, (r == 0), "rand");
      after_done("rand");
    end
  endtask

  task automatic test_timeout();
    bring_up();
    valid = 1'b0;
    for (int unsigned j = 1; j < TO; j++) begin
      tick();
      n_cmp++;
      if (obs !== spec_outs(RUN)) begin
        n_bad++;
        $display("FAIL timeout_wait[%0d]: got outs=%b want %b", j, obs, spec_outs(RUN));
      end
    end
    tick();
    n_cmp++;
    if (obs !== spec_outs(FAULT)) begin
      n_bad++;
      $display("FAIL timeout_fault: got outs=%b want %b", obs, spec_outs(FAULT));
    end
    start = 1'b1; valid = 1'b1;
    tick();
    start = 1'b0; valid = 1'b0;
    tick();
    n_cmp++;
    if (obs !== spec_outs(FAULT) || word_count !== 16'd0) begin
      n_bad++;
      $display("FAIL fault_hold: got outs=%b wc=%0d want outs=%b wc=0", obs, word_count, spec_outs(FAULT));
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++;
    if (obs !== spec_outs(IDLE)) begin
      n_bad++;
      $display("FAIL fault_clear: got outs=%b want %b", obs, spec_outs(IDLE));
    end
  endtask

  task automatic test_abort();
    bring_up();
    for (int unsigned w = 1; w < ABORT_AT; w++) begin
      valid = 1'b0;
      tick();
      valid = 1'b1;
      tick();
    end
    valid = 1'b1; abort = 1'b1;
    tick();
    valid = 1'b0; abort = 1'b0;
    n_cmp++;
    if (obs !== spec_outs(IDLE) || word_count !== 16'(ABORT_AT - 1)) begin
      n_bad++;
      $display("FAIL abort_valid: got outs=%b wc=%0d want outs=%b wc=%0d",
               obs, word_count, spec_outs(IDLE), ABORT_AT - 1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (obs !== spec_outs(IDLE)) begin
        n_bad++;
        $display("FAIL abort_nodone[%0d]: got outs=%b want %b", k, obs, spec_outs(IDLE));
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (obs !== spec_outs(IDLE) || word_count !== 16'd0) begin
      n_bad++;
      $display("FAIL abort_clear: got outs=%b wc=%0d want outs=%b wc=0", obs, word_count, spec_outs(IDLE));
    end
  endtask

  task automatic test_rst_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (CLR + 1) tick();
    n_cmp++;
    if (obs !== spec_outs(ARMS)) begin
      n_bad++;
      $display("FAIL rstmid_arm: got outs=%b want %b", obs, spec_outs(ARMS));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (obs !== spec_outs(IDLE) || word_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rstmid_arm_reset: got outs=%b wc=%0d want outs=%b wc=0", obs, word_count, spec_outs(IDLE));
    end
    bring_up();
    valid = 1'b1;
    repeat (3) tick();
    valid = 1'b0;
    n_cmp++;
    if (word_count !== 16'd3) begin
      n_bad++;
      $display("FAIL rstmid_count: got wc=%0d want 3", word_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (obs !== spec_outs(IDLE) || word_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rstmid_run_reset: got outs=%b wc=%0d want outs=%b wc=0", obs, word_count, spec_outs(IDLE));
    end
  endtask

`ifdef LINK_SEQ_AUTO_RESTART_EN
  task automatic test_auto_restart();
    bring_up();
    for (int b = 0; b < 3; b++) begin
      run_burst(0, 3, 1'b0, "auto");
      tick();
      n_cmp++;
      if (obs !== spec_outs(CLEAR) || word_count !== 16'd0) begin
        n_bad++;
        $display("FAIL auto_reclear[%0d]: got outs=%b wc=%0d want outs=%b wc=0",
                 b, obs, word_count, spec_outs(CLEAR));
      end
      repeat (CLR + ARM - 1) tick();
      n_cmp++;
      if (obs !== spec_outs(RUN)) begin
        n_bad++;
        $display("FAIL auto_rerun[%0d]: got outs=%b want %b", b, obs, spec_outs(RUN));
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    n_cmp++;
    if (obs !== spec_outs(IDLE)) begin
      n_bad++;
      $display("FAIL auto_abort: got outs=%b want %b", obs, spec_outs(IDLE));
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; clr_err = 1'b0; valid = 1'b0;
    test_reset();
    test_bringup();
    test_burst();
    test_random();
    test_timeout();
    test_abort();
    test_rst_mid();
`ifdef LINK_SEQ_AUTO_RESTART_EN
    test_auto_restart();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
